// File: rtl/fast_arc_score_pkg.sv
// fast_pkg: shared types for the FAST corner score block.
//   score_mode_e : scoring mode encodings carried on the 2-bit mode port
//                  (value 3 is unassigned and is scored like MIN_MASK).
//   fsm_state_e  : control states of fast_arc_score.
package fast_pkg;

   typedef enum logic [1:0] {
      MIN_MASK = 2'd0,
      ARC_MAX  = 2'd1,
      SAD      = 2'd2
   } score_mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } fsm_state_e;

endpackage

// File: rtl/fast_arc_score_eval.sv
// fast_arc_eval: combinational evaluator for one contiguous arc on the circle.
//   pixels    in  NUM_PIX*DATA_WIDTH  registered circle intensities, slot i at [i*DATA_WIDTH +: DATA_WIDTH]
//   center    in  DATA_WIDTH          registered center intensity
//   start_idx in  IDX_W               first circle index of the arc
//   arc_value out DATA_WIDTH          max(min bright diff, min dark diff) over the arc
//   arc_dark  out 1                   dark minimum strictly exceeded the bright minimum
module fast_arc_eval
   import fast_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned NUM_PIX    = 16,
   parameter int unsigned ARC_LEN    = 9,
   parameter int unsigned IDX_W      = $clog2(NUM_PIX)
) (
   input  logic [NUM_PIX*DATA_WIDTH-1:0] pixels,
   input  logic [DATA_WIDTH-1:0]         center,
   input  logic [IDX_W-1:0]              start_idx,
   output logic [DATA_WIDTH-1:0]         arc_value,
   output logic                          arc_dark
);

   logic [DATA_WIDTH-1:0] min_b;
   logic [DATA_WIDTH-1:0] min_d;

   always_comb begin : arc_min
      int unsigned           pos;
      logic [DATA_WIDTH-1:0] px;
      logic [DATA_WIDTH-1:0] bd;
      logic [DATA_WIDTH-1:0] dd;
      pos   = 0;
      px    = '0;
      bd    = '0;
      dd    = '0;
      min_b = '1;
      min_d = '1;
      for (int unsigned k = 0; k < ARC_LEN; k++) begin
         // start_idx < NUM_PIX and k < NUM_PIX, so one subtraction wraps the index
         pos = 32'(start_idx) + k;
         if (pos >= NUM_PIX) begin
            pos = pos - NUM_PIX;
         end
         px = pixels[pos*DATA_WIDTH +: DATA_WIDTH];
         bd = (px > center) ? px - center : '0;
         dd = (center > px) ? center - px : '0;
         if (bd < min_b) min_b = bd;
         if (dd < min_d) min_d = dd;
      end
   end

   always_comb begin
      arc_dark  = (min_d > min_b);
      arc_value = arc_dark ? min_d : min_b;
   end

endmodule

// File: rtl/fast_arc_score.sv
// fast_arc_score: corner-strength scorer for a FAST candidate.
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid/in_ready  request handshake; in_ready is high only while idle
//   is_corner       candidate passed the segment test (0 forces score 0)
//   center_pixel    center intensity
//   circle_pixel    packed circle intensities, slot i at [i*DATA_WIDTH +: DATA_WIDTH]
//   bright_mask     per-pixel bright-test pass
//   dark_mask       per-pixel dark-test pass
//   threshold       segment-test threshold (SAD mode)
//   mode            0 MIN_MASK, 1 ARC_MAX, 2 SAD, 3 behaves as MIN_MASK
//   out_valid/out_ready  result handshake; score held while out_ready is low
//   score           corner strength, SCORE_WIDTH bits
//   score_dark      winning ARC_MAX polarity was dark
// MIN_MASK/SAD and non-corner requests produce a result one clock after
// acceptance; ARC_MAX corners scan one arc start per clock, NUM_PIX clocks.
module fast_arc_score
   import fast_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH  = 8,
   parameter  int unsigned NUM_PIX     = 16,
   parameter  int unsigned ARC_LEN     = 9,
   localparam int unsigned SCORE_WIDTH = DATA_WIDTH + $clog2(NUM_PIX)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          is_corner,
   input  logic [DATA_WIDTH-1:0]         center_pixel,
   input  logic [NUM_PIX*DATA_WIDTH-1:0] circle_pixel,
   input  logic [NUM_PIX-1:0]            bright_mask,
   input  logic [NUM_PIX-1:0]            dark_mask,
   input  logic [DATA_WIDTH-1:0]         threshold,
   input  logic [1:0]                    mode,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [SCORE_WIDTH-1:0]        score,
   output logic                          score_dark
);

   localparam int unsigned IDX_W = $clog2(NUM_PIX);

   fsm_state_e                    state_q,     state_d;
   logic [DATA_WIDTH-1:0]         center_q,    center_d;
   logic [NUM_PIX*DATA_WIDTH-1:0] pixels_q,    pixels_d;
   logic [NUM_PIX-1:0]            bmask_q,     bmask_d;
   logic [NUM_PIX-1:0]            dmask_q,     dmask_d;
   logic [DATA_WIDTH-1:0]         thr_q,       thr_d;
   logic [1:0]                    mode_q,      mode_d;
   logic                          corner_q,    corner_d;
   logic [IDX_W-1:0]              idx_q,       idx_d;
   logic [DATA_WIDTH-1:0]         best_q,      best_d;
   logic                          best_dark_q, best_dark_d;
   logic [SCORE_WIDTH-1:0]        score_q,     score_d;
   logic                          score_dark_q, score_dark_d;
   logic                          out_valid_q, out_valid_d;

   logic [DATA_WIDTH-1:0]  arc_val;
   logic                   arc_dark;
   logic [DATA_WIDTH-1:0]  win_val;
   logic                   win_dark;
   logic [DATA_WIDTH-1:0]  min_v;
   logic [SCORE_WIDTH-1:0] sad_v;

   fast_arc_eval #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_PIX    (NUM_PIX),
      .ARC_LEN    (ARC_LEN),
      .IDX_W      (IDX_W)
   ) u_eval (
      .pixels    (pixels_q),
      .center    (center_q),
      .start_idx (idx_q),
      .arc_value (arc_val),
      .arc_dark  (arc_dark)
   );

   // Masked minimum and thresholded sum, both from the registered request.
   always_comb begin : mask_score
      logic [DATA_WIDTH-1:0] px;
      logic [DATA_WIDTH-1:0] bd;
      logic [DATA_WIDTH-1:0] dd;
      px    = '0;
      bd    = '0;
      dd    = '0;
      min_v = '1;
      sad_v = '0;
      for (int unsigned i = 0; i < NUM_PIX; i++) begin
         px = pixels_q[i*DATA_WIDTH +: DATA_WIDTH];
         bd = (px > center_q) ? px - center_q : '0;
         dd = (center_q > px) ? center_q - px : '0;
         if (bmask_q[i]) begin
            if (bd < min_v) min_v = bd;
            if (bd > thr_q) sad_v = sad_v + SCORE_WIDTH'(bd - thr_q);
         end
         if (dmask_q[i]) begin
            if (dd < min_v) min_v = dd;
            if (dd > thr_q) sad_v = sad_v + SCORE_WIDTH'(dd - thr_q);
         end
      end
   end

   // Strict compare keeps the earliest start index on ties.
   always_comb begin
      win_val  = best_q;
      win_dark = best_dark_q;
      if (arc_val > best_q) begin
         win_val  = arc_val;
         win_dark = arc_dark;
      end
   end

   always_comb begin
      state_d      = state_q;
      center_d     = center_q;
      pixels_d     = pixels_q;
      bmask_d      = bmask_q;
      dmask_d      = dmask_q;
      thr_d        = thr_q;
      mode_d       = mode_q;
      corner_d     = corner_q;
      idx_d        = idx_q;
      best_d       = best_q;
      best_dark_d  = best_dark_q;
      score_d      = score_q;
      score_dark_d = score_dark_q;
      out_valid_d  = out_valid_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               center_d    = center_pixel;
               pixels_d    = circle_pixel;
               bmask_d     = bright_mask;
               dmask_d     = dark_mask;
               thr_d       = threshold;
               mode_d      = mode;
               corner_d    = is_corner;
               idx_d       = '0;
               best_d      = '0;
               best_dark_d = 1'b0;
               out_valid_d = 1'b0;
               state_d     = (mode == ARC_MAX && is_corner) ? SCAN : DONE;
            end
         end
         SCAN: begin
            best_d      = win_val;
            best_dark_d = win_dark;
            idx_d       = idx_q + 1'b1;
            if (idx_q == IDX_W'(NUM_PIX - 1)) begin
               score_d      = SCORE_WIDTH'(win_val);
               score_dark_d = win_dark;
               out_valid_d  = 1'b1;
               state_d      = DONE;
            end
         end
         DONE: begin
            // First DONE cycle of a single-cycle mode computes the result;
            // ARC_MAX arrives here with out_valid already set.
            if (!out_valid_q) begin
               score_dark_d = 1'b0;
               out_valid_d  = 1'b1;
               if (!corner_q) begin
                  score_d = '0;
               end else if (mode_q == SAD) begin
                  score_d = sad_v;
               end else begin
                  score_d = SCORE_WIDTH'(min_v);
               end
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         center_q     <= '0;
         pixels_q     <= '0;
         bmask_q      <= '0;
         dmask_q      <= '0;
         thr_q        <= '0;
         mode_q       <= '0;
         corner_q     <= 1'b0;
         idx_q        <= '0;
         best_q       <= '0;
         best_dark_q  <= 1'b0;
         score_q      <= '0;
         score_dark_q <= 1'b0;
         out_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         center_q     <= center_d;
         pixels_q     <= pixels_d;
         bmask_q      <= bmask_d;
         dmask_q      <= dmask_d;
         thr_q        <= thr_d;
         mode_q       <= mode_d;
         corner_q     <= corner_d;
         idx_q        <= idx_d;
         best_q       <= best_d;
         best_dark_q  <= best_dark_d;
         score_q      <= score_d;
         score_dark_q <= score_dark_d;
         out_valid_q  <= out_valid_d;
      end
   end

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = out_valid_q;
   assign score      = score_q;
   assign score_dark = score_dark_q;

endmodule

// File: tb/tb_fast_arc_score.sv
module tb_fast_arc_score;

   localparam int DW = 8;
   localparam int NP = 16;
   localparam int AL = 9;
   localparam int SW = DW + $clog2(NP);

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic            is_corner = 1'b0;
   logic [DW-1:0]   center_pixel = '0;
   logic [NP*DW-1:0] circle_pixel = '0;
   logic [NP-1:0]   bright_mask = '0;
   logic [NP-1:0]   dark_mask = '0;
   logic [DW-1:0]   threshold = '0;
   logic [1:0]      mode = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [SW-1:0]   score;
   logic            score_dark;

   int vectors = 0;
   int miscompares = 0;

   // current request
   int v_center;
   int v_px[NP];
   int v_bm, v_dm, v_thr, v_mode, v_corner;

   fast_arc_score #(.DATA_WIDTH(DW), .NUM_PIX(NP), .ARC_LEN(AL)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .is_corner    (is_corner),
      .center_pixel (center_pixel),
      .circle_pixel (circle_pixel),
      .bright_mask  (bright_mask),
      .dark_mask    (dark_mask),
      .threshold    (threshold),
      .mode         (mode),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .score        (score),
      .score_dark   (score_dark)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int bdiff(input int p, input int c);
      return (p > c) ? p - c : 0;
   endfunction

   function automatic int ddiff(input int p, input int c);
      return (c > p) ? c - p : 0;
   endfunction

   // Reference scorer written straight from the scoring rules.
   task automatic model(output int e_score, output int e_dark, output int e_lat);
      int q[$];
      int best, bdark, mb, md, v, p, sum;
      e_dark = 0;
      e_lat  = 1;
      if (v_corner == 0) begin
         e_score = 0;
      end else if (v_mode == 1) begin
         e_lat = NP;
         best = 0;
         bdark = 0;
         for (int s = 0; s < NP; s++) begin
            mb = 255;
            md = 255;
            for (int k = 0; k < AL; k++) begin
               p = v_px[(s + k) % NP];
               if (bdiff(p, v_center) < mb) mb = bdiff(p, v_center);
               if (ddiff(p, v_center) < md) md = ddiff(p, v_center);
            end
            v = (md > mb) ? md : mb;
            if (v > best) begin
               best = v;
               bdark = (md > mb) ? 1 : 0;
            end
         end
         e_score = best;
         e_dark  = bdark;
      end else if (v_mode == 2) begin
         sum = 0;
         for (int i = 0; i < NP; i++) begin
            if (v_bm[i]) sum += (bdiff(v_px[i], v_center) > v_thr) ? bdiff(v_px[i], v_center) - v_thr : 0;
            if (v_dm[i]) sum += (ddiff(v_px[i], v_center) > v_thr) ? ddiff(v_px[i], v_center) - v_thr : 0;
         end
         e_score = sum;
      end else begin
         for (int i = 0; i < NP; i++) begin
            if (v_bm[i]) q.push_back(bdiff(v_px[i], v_center));
            if (v_dm[i]) q.push_back(ddiff(v_px[i], v_center));
         end
         e_score = 255;
         foreach (q[j]) if (q[j] < e_score) e_score = q[j];
      end
   endtask

   task automatic set_req(input int c, input int fill, input int bm, input int dm,
                          input int thr, input int md, input int corner);
      v_center = c;
      for (int i = 0; i < NP; i++) v_px[i] = fill;
      v_bm = bm; v_dm = dm; v_thr = thr; v_mode = md; v_corner = corner;
   endtask

   task automatic drive_req();
      center_pixel = v_center[DW-1:0];
      for (int i = 0; i < NP; i++) circle_pixel[i*DW +: DW] = v_px[i][DW-1:0];
      bright_mask = v_bm[NP-1:0];
      dark_mask   = v_dm[NP-1:0];
      threshold   = v_thr[DW-1:0];
      mode        = v_mode[1:0];
      is_corner   = v_corner[0];
      in_valid    = 1'b1;
   endtask

   task automatic scramble_inputs();
      in_valid     = 1'b1;
      center_pixel = DW'($urandom);
      for (int i = 0; i < NP; i++) circle_pixel[i*DW +: DW] = DW'($urandom);
      bright_mask = NP'($urandom);
      dark_mask   = NP'($urandom);
      threshold   = DW'($urandom);
      mode        = 2'($urandom);
      is_corner   = 1'($urandom);
   endtask

   // One full request: accept, wait for the result, hold for 'hold'
   // cycles of backpressure, then complete the handshake.
   task automatic run_txn(input string name, input int hold, input bit has_lit,
                          input int lit_score, input int lit_dark);
      int e_score, e_dark, e_lat, n, held;
      model(e_score, e_dark, e_lat);
      if (has_lit) begin
         check({name, "_model_score"}, e_score, lit_score);
         check({name, "_model_dark"}, e_dark, lit_dark);
      end
      @(negedge clk);
      check({name, "_in_ready_idle"}, int'(in_ready), 1);
      drive_req();
      @(posedge clk);
      @(negedge clk);
      scramble_inputs();
      n = 0;
      while (!out_valid && n < 40) begin
         if (in_ready) check({name, "_in_ready_busy"}, int'(in_ready), 0);
         @(negedge clk);
         n++;
      end
      check({name, "_latency"}, n, e_lat);
      if (n < 40) begin
         check({name, "_score"}, int'(score), e_score);
         check({name, "_dark"}, int'(score_dark), e_dark);
         held = int'(score);
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({name, "_hold_valid"}, int'(out_valid), 1);
            check({name, "_hold_score"}, int'(score), held);
            check({name, "_hold_in_ready"}, int'(in_ready), 0);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check({name, "_release_in_ready"}, int'(in_ready), 1);
      check({name, "_release_valid"}, int'(out_valid), 0);
   endtask

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      check("reset_in_ready", int'(in_ready), 1);
      check("reset_valid", int'(out_valid), 0);
      check("reset_score", int'(score), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_in_ready", int'(in_ready), 1);

      // uniform bright arc
      set_req(100, 130, 0, 0, 0, 1, 1);
      run_txn("arc_uniform", 0, 1, 30, 0);

      // wrap-around arc starting at 12
      set_req(100, 100, 0, 0, 0, 1, 1);
      for (int i = 12; i < 16; i++) v_px[i] = 200;
      for (int i = 0; i <= 4; i++) v_px[i] = 200;
      run_txn("arc_wrap", 0, 1, 100, 0);

      // dark arc sets polarity
      set_req(100, 40, 0, 0, 0, 1, 1);
      run_txn("arc_dark", 0, 1, 60, 1);

      // ARC_MAX non-corner is scored immediately as zero
      set_req(100, 130, 0, 0, 0, 1, 0);
      run_txn("arc_noncorner", 0, 1, 0, 0);

      // masked minimum
      set_req(100, 100, 16'h01FF, 0, 0, 0, 1);
      for (int i = 0; i <= 8; i++) v_px[i] = 120 + i;
      run_txn("min_mask", 0, 1, 20, 0);

      // both masks empty saturates
      set_req(100, 90, 0, 0, 0, 0, 1);
      run_txn("min_empty", 0, 1, 255, 0);

      // reserved mode behaves as masked minimum
      set_req(50, 50, 16'h0008, 16'h0020, 0, 3, 1);
      v_px[3] = 60;
      v_px[5] = 45;
      run_txn("mode3_min", 0, 1, 5, 0);

      // thresholded sum of saturated differences
      set_req(200, 50, 0, 16'hFFFF, 20, 2, 1);
      run_txn("sad_full", 0, 1, 2080, 0);
      set_req(200, 50, 0, 16'hFFFF, 20, 2, 0);
      run_txn("sad_noncorner", 0, 1, 0, 0);

      // threshold above every difference
      set_req(100, 110, 16'hFFFF, 16'hFFFF, 30, 2, 1);
      run_txn("sad_below_thr", 0, 1, 0, 0);

      // backpressure in DONE
      set_req(200, 50, 0, 16'hFFFF, 20, 2, 1);
      run_txn("backpressure", 5, 1, 2080, 0);

      // random requests against the model only
      for (int r = 0; r < 8; r++) begin
         v_center = $urandom_range(0, 255);
         for (int i = 0; i < NP; i++) v_px[i] = $urandom_range(0, 255);
         v_bm     = $urandom_range(0, 65535);
         v_dm     = $urandom_range(0, 65535);
         v_thr    = $urandom_range(0, 60);
         v_mode   = $urandom_range(0, 3);
         v_corner = (r == 0) ? 1 : $urandom_range(0, 1);
         if (r < 3) v_mode = 1;
         run_txn("random", r % 3, 0, 0, 0);
      end

      // reset while scanning start index 7
      set_req(100, 40, 0, 0, 0, 1, 1);
      @(negedge clk);
      drive_req();
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      check("pre_reset_busy", int'(in_ready), 0);
      rst_n = 1'b0;
      #1;
      check("midscan_reset_valid", int'(out_valid), 0);
      check("midscan_reset_score", int'(score), 0);
      check("midscan_reset_dark", int'(score_dark), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("midscan_release_in_ready", int'(in_ready), 1);
      check("midscan_release_valid", int'(out_valid), 0);
      set_req(100, 130, 0, 0, 0, 1, 1);
      run_txn("after_reset", 0, 1, 30, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
